// File: rtl/split_bytes_if.sv
// Stream bundle for split_bytes: wide-word input side, narrow-chunk output side, DONE pulse.
// Valid/ready rule on both sides: a beat transfers on a rising edge where the EN and RD_EN signals are both high.
interface split_bytes_if #(
  parameter int C_IN_BYTES  = 4,
  parameter int C_OUT_BYTES = 1
);
  localparam int C_IN_WIDTH    = 8 * C_IN_BYTES;
  localparam int C_OUT_WIDTH   = 8 * C_OUT_BYTES;
  localparam int C_BYTES_WIDTH = ($clog2(C_IN_BYTES + 1) < 1) ? 1 : $clog2(C_IN_BYTES + 1);

  logic                     INDATA_EN;
  logic [C_IN_WIDTH-1:0]    INDATA;
  logic                     INDATA_LAST;
  logic [C_BYTES_WIDTH-1:0] INDATA_BYTES;
  logic                     INDATA_RD_EN;
  logic                     OUTDATA_EN;
  logic [C_OUT_WIDTH-1:0]   OUTDATA;
  logic                     OUTDATA_LAST;
  logic                     OUTDATA_RD_EN;
  logic                     DONE;
  logic                     DBG_STATE;  // 0 = EMPTY, 1 = DRAIN

  modport slave (
    input  INDATA_EN, INDATA, INDATA_LAST, INDATA_BYTES, OUTDATA_RD_EN,
    output INDATA_RD_EN, OUTDATA_EN, OUTDATA, OUTDATA_LAST, DONE, DBG_STATE
  );

  modport master (
    output INDATA_EN, INDATA, INDATA_LAST, INDATA_BYTES, OUTDATA_RD_EN,
    input  INDATA_RD_EN, OUTDATA_EN, OUTDATA, OUTDATA_LAST, DONE, DBG_STATE
  );
endinterface

// File: rtl/split_bytes.sv
// Splits wide words into narrow chunks, least-significant chunk first, honouring a short final word.
// A new word can be captured on the same edge the last chunk of the previous one leaves (zero bubble).
module split_bytes #(
  parameter int C_IN_BYTES  = 4,
  parameter int C_OUT_BYTES = 1
) (
  input  logic          CLK,
  input  logic          RST,
  split_bytes_if.slave  bus
);
  localparam int C_IN_WIDTH    = 8 * C_IN_BYTES;
  localparam int C_OUT_WIDTH   = 8 * C_OUT_BYTES;
  localparam int C_RATIO       = C_IN_BYTES / C_OUT_BYTES;
  localparam int C_CNT_WIDTH   = ($clog2(C_RATIO + 1) < 1) ? 1 : $clog2(C_RATIO + 1);
  localparam int C_BYTES_WIDTH = ($clog2(C_IN_BYTES + 1) < 1) ? 1 : $clog2(C_IN_BYTES + 1);

  typedef enum logic {S_EMPTY = 1'b0, S_DRAIN = 1'b1} state_e;

  logic [C_IN_WIDTH-1:0]    data_q, data_d;
  logic [C_CNT_WIDTH-1:0]   remain_q, remain_d;
  logic                     last_q, last_d;
  logic                     done_q, done_d;

  state_e                   state;
  logic [C_BYTES_WIDTH-1:0] nbytes;
  logic [C_IN_WIDTH-1:0]    masked;
  logic [C_CNT_WIDTH-1:0]   cap_remain;
  logic                     in_rd_en;
  logic                     out_en;
  logic                     out_last;
  logic                     in_fire;
  logic                     out_fire;

  // Capture-side shaping: trim a short final word and work out how many chunks it yields.
  always_comb begin
    nbytes = C_BYTES_WIDTH'(C_IN_BYTES);
    if (bus.INDATA_LAST && (bus.INDATA_BYTES != '0) &&
        (bus.INDATA_BYTES < C_BYTES_WIDTH'(C_IN_BYTES)))
      nbytes = bus.INDATA_BYTES;
    masked = bus.INDATA;
    for (int b = 0; b < C_IN_BYTES; b++) begin
      if (C_BYTES_WIDTH'(b) >= nbytes) masked[b*8 +: 8] = 8'h00;
    end
    cap_remain = bus.INDATA_LAST
               ? C_CNT_WIDTH'((32'(nbytes) + C_OUT_BYTES - 1) / C_OUT_BYTES)
               : C_CNT_WIDTH'(C_RATIO);
  end

  always_comb begin
    state    = (remain_q != '0) ? S_DRAIN : S_EMPTY;
    out_en   = (state == S_DRAIN);
    out_last = last_q && (remain_q == C_CNT_WIDTH'(1));
    in_rd_en = (state == S_EMPTY) ||
               ((remain_q == C_CNT_WIDTH'(1)) && bus.OUTDATA_RD_EN);
    in_fire  = bus.INDATA_EN && in_rd_en;
    out_fire = out_en && bus.OUTDATA_RD_EN;

    data_d   = data_q;
    remain_d = remain_q;
    last_d   = last_q;
    done_d   = out_fire && out_last;

    // Capture wins over the shift when the last chunk leaves as a new word arrives.
    if (in_fire) begin
      data_d   = masked;
      remain_d = cap_remain;
      last_d   = bus.INDATA_LAST;
    end else if (out_fire) begin
      data_d   = data_q >> C_OUT_WIDTH;
      remain_d = remain_q - C_CNT_WIDTH'(1);
      if (remain_q == C_CNT_WIDTH'(1)) last_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q   <= '0;
      remain_q <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      remain_q <= remain_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign bus.INDATA_RD_EN = in_rd_en;
  assign bus.OUTDATA_EN   = out_en;
  assign bus.OUTDATA      = data_q[C_OUT_WIDTH-1:0];
  assign bus.OUTDATA_LAST = out_last;
  assign bus.DONE         = done_q;
  assign bus.DBG_STATE    = state;
endmodule
